// File: rtl/pwd_entry_ctrl.sv
// Password-entry sequencer: debounced switches/key, password compare, attempt
// counting with timed lockout, Avalon-MM register file and masked interrupt.
module pwd_entry_ctrl #(
  parameter int              DW              = 18,
  parameter int              DEBOUNCE_CYCLES = 500000,
  parameter int              MAX_ATTEMPTS    = 3,
  parameter int              LOCKOUT_CYCLES  = 250000000,
  parameter logic [DW-1:0]   RESET_PWD       = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          irq,
  input  logic [DW-1:0] sw_in,
  input  logic          submit_n,
  output logic          unlocked,
  output logic          locked_out
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW  = $clog2(MAX_ATTEMPTS + 1);
  localparam int TW  = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_GRANT   = 3'd2,
    S_DENY    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  logic [DW-1:0]  r_sw_s1, r_sw_s2, r_sw_lvl, r_sw_stable;
  logic [DBW-1:0] r_sw_cnt, r_key_cnt;
  logic           r_sub_s1, r_sub_s2, r_key_lvl, r_armed;
  logic [DW-1:0]  r_entry, r_pwd;
  logic [3:0]     r_ctrl;
  logic           r_grant_evt, r_deny_evt, r_lock_evt;
  logic [AW-1:0]  r_attempts;
  logic [TW-1:0]  r_timer;
  state_t         r_state;

  state_t         w_state_nxt;
  logic [AW-1:0]  w_attempts_nxt;
  logic [TW-1:0]  w_timer_nxt;
  logic           w_set_grant, w_set_deny, w_set_lock, w_latch;
  logic           w_sw_hit, w_key_hit, w_press;
  logic           w_wr, w_wr_pwd, w_wr_ctrl, w_wr_st;
  logic           w_grant_nxt, w_deny_nxt, w_lock_nxt;
  logic [3:0]     w_ctrl_nxt;
  logic [31:0]    w_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_sub_s1 <= 1'b0;
      r_sub_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
      r_sub_s1 <= submit_n;
      r_sub_s2 <= r_sub_s1;
    end
  end

  // Hit fires exactly once per stable period: the cycle the count reaches the limit.
  assign w_sw_hit  = (r_sw_s2 == r_sw_lvl) && (r_sw_cnt == DBW'(DEBOUNCE_CYCLES - 1));
  assign w_key_hit = (r_sub_s2 == r_key_lvl) && (r_key_cnt == DBW'(DEBOUNCE_CYCLES - 1));
  assign w_press   = w_key_hit && !r_key_lvl && r_armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_lvl    <= '0;
      r_sw_cnt    <= '0;
      r_sw_stable <= '0;
    end else begin
      if (r_sw_s2 != r_sw_lvl) begin
        r_sw_lvl <= r_sw_s2;
        r_sw_cnt <= '0;
      end else if (r_sw_cnt != DBW'(DEBOUNCE_CYCLES)) begin
        r_sw_cnt <= r_sw_cnt + DBW'(1);
      end
      if (w_sw_hit) r_sw_stable <= r_sw_lvl;
    end
  end

  // Armed only after a debounced release, so a held button yields one press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_lvl <= 1'b0;
      r_key_cnt <= '0;
      r_armed   <= 1'b0;
    end else begin
      if (r_sub_s2 != r_key_lvl) begin
        r_key_lvl <= r_sub_s2;
        r_key_cnt <= '0;
      end else if (r_key_cnt != DBW'(DEBOUNCE_CYCLES)) begin
        r_key_cnt <= r_key_cnt + DBW'(1);
      end
      if (w_key_hit) r_armed <= r_key_lvl;
    end
  end

  assign w_wr      = chipselect && !write_n;
  assign w_wr_pwd  = w_wr && (address == 2'd1);
  assign w_wr_ctrl = w_wr && (address == 2'd2);
  assign w_wr_st   = w_wr && (address == 2'd3);

  always_comb begin
    w_state_nxt    = r_state;
    w_attempts_nxt = r_attempts;
    w_timer_nxt    = r_timer;
    w_set_grant    = 1'b0;
    w_set_deny     = 1'b0;
    w_set_lock     = 1'b0;
    w_latch        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press && r_ctrl[0]) begin
          w_latch     = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_entry == r_pwd) begin
          w_attempts_nxt = '0;
          w_set_grant    = 1'b1;
          w_state_nxt    = S_GRANT;
        end else if ((32'(r_attempts) + 32'd1) < 32'(MAX_ATTEMPTS)) begin
          w_attempts_nxt = r_attempts + AW'(1);
          w_set_deny     = 1'b1;
          w_state_nxt    = S_DENY;
        end else begin
          w_attempts_nxt = AW'(MAX_ATTEMPTS);
          w_set_lock     = 1'b1;
          w_timer_nxt    = TW'(LOCKOUT_CYCLES - 1);
          w_state_nxt    = S_LOCKOUT;
        end
      end
      S_GRANT: begin
        if (w_wr_st && writedata[0]) w_state_nxt = S_IDLE;
      end
      S_DENY: w_state_nxt = S_IDLE;
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_attempts_nxt = '0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_attempts <= '0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_attempts <= w_attempts_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  // A new event in the same cycle as its W1C clear keeps the event set.
  assign w_grant_nxt = (r_grant_evt & ~(w_wr_st & writedata[2])) | w_set_grant;
  assign w_deny_nxt  = (r_deny_evt  & ~(w_wr_st & writedata[3])) | w_set_deny;
  assign w_lock_nxt  = (r_lock_evt  & ~(w_wr_st & writedata[4])) | w_set_lock;
  assign w_ctrl_nxt  = w_wr_ctrl ? writedata[3:0] : r_ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwd       <= RESET_PWD;
      r_ctrl      <= '0;
      r_entry     <= '0;
      r_grant_evt <= 1'b0;
      r_deny_evt  <= 1'b0;
      r_lock_evt  <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (w_wr_pwd) r_pwd <= writedata[DW-1:0];
      if (w_latch)  r_entry <= r_sw_stable;
      r_ctrl      <= w_ctrl_nxt;
      r_grant_evt <= w_grant_nxt;
      r_deny_evt  <= w_deny_nxt;
      r_lock_evt  <= w_lock_nxt;
      irq         <= |({w_lock_nxt, w_deny_nxt, w_grant_nxt} & w_ctrl_nxt[3:1]);
    end
  end

  assign unlocked   = (r_state == S_GRANT);
  assign locked_out = (r_state == S_LOCKOUT);

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0: w_rdata = 32'(r_sw_stable);
      2'd2: w_rdata = {28'b0, r_ctrl};
      2'd3: w_rdata = {13'b0, r_state, 8'(r_attempts), 3'b0,
                       r_lock_evt, r_deny_evt, r_grant_evt, locked_out, unlocked};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rdata;
  end

endmodule

// File: tb/tb_pwd_entry_ctrl.sv
// Directed bench for pwd_entry_ctrl with short debounce/lockout timing.
module tb_pwd_entry_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [17:0] sw_in;
  logic        submit_n;
  logic        unlocked;
  logic        locked_out;

  int checks = 0;
  int errors = 0;
  int lock_cycles = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (locked_out === 1'b1) lock_cycles++;

  pwd_entry_ctrl #(
    .DW(18), .DEBOUNCE_CYCLES(4), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(20), .RESET_PWD(18'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .sw_in(sw_in), .submit_n(submit_n), .unlocked(unlocked), .locked_out(locked_out)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  task automatic key_low(input int n);
    submit_n = 1'b0;
    tick(n);
  endtask

  task automatic key_high(input int n);
    submit_n = 1'b1;
    tick(n);
  endtask

  task automatic press();
    key_low(10);
    key_high(10);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; sw_in = '0; submit_n = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_rd%0d: got %h expected %h", a, d, 32'h0); end
    end
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %b expected 0", unlocked); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_grant();
    logic [31:0] d;
    wr(2'd1, 32'h2A5A5);
    wr(2'd2, 32'h3);
    sw_in = 18'h2A5A5;
    tick(10);
    press();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h00020005) begin errors++; $display("FAIL grant_status: got %h expected %h", d, 32'h00020005); end
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL grant_unlocked: got %b expected 1", unlocked); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL grant_irq: got %b expected 1", irq); end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0002A5A5) begin errors++; $display("FAIL grant_sw: got %h expected %h", d, 32'h0002A5A5); end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL grant_ctrl: got %h expected %h", d, 32'h3); end
    wr(2'd3, 32'h5);
    tick(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL relock_irq: got %b expected 0", irq); end
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL relock_unlocked: got %b expected 0", unlocked); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL relock_status: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    fork
      press();
      for (int i = 0; i < 10; i++) begin
        sw_in = i[0] ? 18'h00000 : 18'h3FFFF;
        tick(2);
      end
    join
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0002A5A5) begin errors++; $display("FAIL bounce_sw_hold: got %h expected %h", d, 32'h0002A5A5); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h00020005) begin errors++; $display("FAIL bounce_old_cmp: got %h expected %h", d, 32'h00020005); end
    wr(2'd3, 32'h5);
    for (int i = 0; i < 10; i++) begin
      submit_n = i[0];
      tick(2);
    end
    key_high(10);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL key_bounce: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_lockout();
    logic [31:0] d;
    int lc0;
    wr(2'd2, 32'h9);
    sw_in = 18'h00001;
    tick(10);
    lc0 = lock_cycles;
    press();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h00000108) begin errors++; $display("FAIL lock_try1: got %h expected %h", d, 32'h00000108); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL lock_deny_masked: got %b expected 0", irq); end
    press();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h00000208) begin errors++; $display("FAIL lock_try2: got %h expected %h", d, 32'h00000208); end
    key_low(10);
    checks++;
    if (locked_out !== 1'b1) begin errors++; $display("FAIL lock_enter: got %b expected 1", locked_out); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL lock_irq: got %b expected 1", irq); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0004031A) begin errors++; $display("FAIL lock_status: got %h expected %h", d, 32'h0004031A); end
    key_high(7);
    key_low(8);
    checks++;
    if (locked_out !== 1'b1) begin errors++; $display("FAIL lock_press_ignored: got %b expected 1", locked_out); end
    key_high(10);
    checks++;
    if (locked_out !== 1'b0) begin errors++; $display("FAIL lock_exit: got %b expected 0", locked_out); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h00000018) begin errors++; $display("FAIL lock_after: got %h expected %h", d, 32'h00000018); end
    checks++;
    if ((lock_cycles - lc0) !== 20) begin errors++; $display("FAIL lock_duration: got %0d expected 20", lock_cycles - lc0); end
  endtask

  task automatic test_retry_enable();
    logic [31:0] d;
    wr(2'd3, 32'h1C);
    wr(2'd2, 32'h1);
    press();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h00000108) begin errors++; $display("FAIL retry_wrong: got %h expected %h", d, 32'h00000108); end
    sw_in = 18'h2A5A5;
    tick(10);
    press();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0002000D) begin errors++; $display("FAIL retry_right: got %h expected %h", d, 32'h0002000D); end
    wr(2'd3, 32'h1D);
    wr(2'd2, 32'h0);
    press();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL enable_off: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr(2'd2, 32'h1);
    sw_in = 18'h00001;
    tick(10);
    // Deny event is set on the same edge the W1C write lands.
    submit_n = 1'b0;
    tick(7);
    wr(2'd3, 32'h8);
    tick(2);
    key_high(10);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h00000108) begin errors++; $display("FAIL w1c_set_wins: got %h expected %h", d, 32'h00000108); end
    press();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h00000208) begin errors++; $display("FAIL b2b_try2: got %h expected %h", d, 32'h00000208); end
    key_low(10);
    checks++;
    if (locked_out !== 1'b1) begin errors++; $display("FAIL b2b_lock: got %b expected 1", locked_out); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (locked_out !== 1'b0) begin errors++; $display("FAIL rst_locked_out: got %b expected 0", locked_out); end
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h expected %h", readdata, 32'h0); end
    tick(2);
    submit_n = 1'b1;
    reset_n = 1'b1;
    tick(2);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h expected %h", d, 32'h0); end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h expected %h", d, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_bounce();
    test_lockout();
    test_retry_enable();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
